// File: rtl/seg7_capture_if.sv
// Report channel for seg7_capture: valid/ready handshake carrying one decoded display snapshot.
interface seg7_capture_if;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_value;
   logic [5:0]  out_blank;
   logic [5:0]  out_error;

   modport master (
      output out_valid,
      output out_value,
      output out_blank,
      output out_error,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_value,
      input  out_blank,
      input  out_error,
      output out_ready
   );
endinterface

// File: rtl/seg7_capture.sv
// seg7_capture: samples six 7-segment digit outputs, decodes them to hex nibbles and
// reports each new value over a valid/ready handshake once it has been stable for
// STABLE_CYCLES samples. Define SEG7_CAPTURE_ACTIVE_LOW_EN for active-low segments.
module seg7_capture #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       seg7_0,
   input  logic [6:0]       seg7_1,
   input  logic [6:0]       seg7_2,
   input  logic [6:0]       seg7_3,
   input  logic [6:0]       seg7_4,
   input  logic [6:0]       seg7_5,
   seg7_capture_if.master   rpt,
   output logic [CNT_W-1:0] report_count
);

   localparam logic [7:0] StableMax = 8'(STABLE_CYCLES - 1);

   typedef enum logic [0:0] {StIdle, StPending} state_e;

   // Returns {error, blank, nibble} for one active-high gfedcba pattern.
   function automatic logic [5:0] decode_digit(input logic [6:0] pat);
      logic [5:0] r;
      r = 6'b000000;
      case (pat)
         7'h3F:   r = 6'h00;
         7'h06:   r = 6'h01;
         7'h5B:   r = 6'h02;
         7'h4F:   r = 6'h03;
         7'h66:   r = 6'h04;
         7'h6D:   r = 6'h05;
         7'h7D:   r = 6'h06;
         7'h07:   r = 6'h07;
         7'h7F:   r = 6'h08;
         7'h6F:   r = 6'h09;
         7'h77:   r = 6'h0A;
         7'h7C:   r = 6'h0B;
         7'h39:   r = 6'h0C;
         7'h5E:   r = 6'h0D;
         7'h79:   r = 6'h0E;
         7'h71:   r = 6'h0F;
         7'h00:   r = 6'b010000;
         default: r = 6'b100000;
      endcase
      return r;
   endfunction

   logic [41:0] raw_vec;
   logic [41:0] in_vec;
   logic [41:0] s_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        stable;

   logic [23:0] cand_value;
   logic [5:0]  cand_blank;
   logic [5:0]  cand_error;
   logic [35:0] cand;

   state_e      state_q, state_d;
   logic        valid_q, valid_d;
   logic [23:0] value_q, value_d;
   logic [5:0]  blank_q, blank_d;
   logic [5:0]  error_q, error_d;
   logic [35:0] last_q, last_d;
   logic        last_none_q, last_none_d;
   logic [CNT_W-1:0] count_q, count_d;

   assign raw_vec = {seg7_5, seg7_4, seg7_3, seg7_2, seg7_1, seg7_0};

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
   assign in_vec = ~raw_vec;
`else
   assign in_vec = raw_vec;
`endif

   // Stability counter: restarts whenever the incoming value differs from the sample.
   always_comb begin
      cnt_d = cnt_q;
      if (in_vec != s_q) begin
         cnt_d = 8'd0;
      end else if (cnt_q != StableMax) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign stable = (cnt_q == StableMax);

   // Decode the sampled display into the report candidate.
   always_comb begin
      logic [5:0] d;
      d          = 6'b000000;
      cand_value = 24'h000000;
      cand_blank = 6'b000000;
      cand_error = 6'b000000;
      for (int k = 0; k < 6; k++) begin
         d                  = decode_digit(s_q[7*k +: 7]);
         cand_value[4*k +: 4] = d[3:0];
         cand_blank[k]        = d[4];
         cand_error[k]        = d[5];
      end
   end

   assign cand = {cand_value, cand_blank, cand_error};

   // Report FSM next-state: IDLE launches a new report, PENDING waits for acceptance.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      value_d     = value_q;
      blank_d     = blank_q;
      error_d     = error_q;
      last_d      = last_q;
      last_none_d = last_none_q;
      count_d     = count_q;
      unique case (state_q)
         StIdle: begin
            if (stable && (last_none_q || (cand != last_q))) begin
               value_d = cand_value;
               blank_d = cand_blank;
               error_d = cand_error;
               valid_d = 1'b1;
               state_d = StPending;
            end
         end
         StPending: begin
            // Payload is frozen here; display changes are re-evaluated after acceptance.
            if (rpt.out_ready) begin
               last_d      = {value_q, blank_q, error_q};
               last_none_d = 1'b0;
               count_d     = count_q + 1'b1;
               valid_d     = 1'b0;
               state_d     = StIdle;
            end
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q         <= '0;
         cnt_q       <= 8'd0;
         state_q     <= StIdle;
         valid_q     <= 1'b0;
         value_q     <= '0;
         blank_q     <= '0;
         error_q     <= '0;
         last_q      <= '0;
         last_none_q <= 1'b1;
         count_q     <= '0;
      end else begin
         s_q         <= in_vec;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         valid_q     <= valid_d;
         value_q     <= value_d;
         blank_q     <= blank_d;
         error_q     <= error_d;
         last_q      <= last_d;
         last_none_q <= last_none_d;
         count_q     <= count_d;
      end
   end

   assign rpt.out_valid = valid_q;
   assign rpt.out_value = value_q;
   assign rpt.out_blank = blank_q;
   assign rpt.out_error = error_q;
   assign report_count  = count_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: scoreboard of expected reports, popped on acceptance.
module tb_seg7_capture;
   localparam int unsigned Stable = 4;
   localparam int unsigned CntW   = 4;

   typedef struct packed {
      logic [23:0] value;
      logic [5:0]  blank;
      logic [5:0]  error;
   } rpt_t;

   logic            clk;
   logic            reset;
   logic [6:0]      seg7_0, seg7_1, seg7_2, seg7_3, seg7_4, seg7_5;
   logic [CntW-1:0] report_count;

   seg7_capture_if rpt ();

   seg7_capture #(
      .STABLE_CYCLES (Stable),
      .CNT_W         (CntW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .seg7_0       (seg7_0),
      .seg7_1       (seg7_1),
      .seg7_2       (seg7_2),
      .seg7_3       (seg7_3),
      .seg7_4       (seg7_4),
      .seg7_5       (seg7_5),
      .rpt          (rpt),
      .report_count (report_count)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned exp_count = 0;
   rpt_t        exp_q[$];

   logic        prev_hold = 1'b0;
   rpt_t        prev_pay;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      logic [6:0] p;
      case (d)
         0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
         4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
         8: p = 7'h7F;  9: p = 7'h6F;  10: p = 7'h77; 11: p = 7'h7C;
         12: p = 7'h39; 13: p = 7'h5E; 14: p = 7'h79; default: p = 7'h71;
      endcase
      return p;
   endfunction

   // Converts a logical gfedcba pattern to what the pins carry in this build.
   function automatic logic [6:0] enc(input logic [6:0] pat);
`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
      return ~pat;
`else
      return pat;
`endif
   endfunction

   task automatic set_digits(input logic [6:0] p5, input logic [6:0] p4, input logic [6:0] p3,
                             input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0);
      seg7_5 = enc(p5);
      seg7_4 = enc(p4);
      seg7_3 = enc(p3);
      seg7_2 = enc(p2);
      seg7_1 = enc(p1);
      seg7_0 = enc(p0);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int max, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!rpt.out_valid && n < max);
      if (!rpt.out_valid) check_eq("valid_timeout", {31'b0, rpt.out_valid}, 32'd1);
   endtask

   task automatic push(input logic [23:0] v, input logic [5:0] b, input logic [5:0] e);
      rpt_t r;
      r.value = v;
      r.blank = b;
      r.error = e;
      exp_q.push_back(r);
      exp_count++;
   endtask

   function automatic logic [31:0] cnt_mod(input int unsigned c);
      return 32'(c % (32'd1 << CntW));
   endfunction

   // Monitor: compares accepted reports against the scoreboard and checks payload hold.
   always @(negedge clk) begin
      rpt_t cur;
      rpt_t exp;
      cur.value = rpt.out_value;
      cur.blank = rpt.out_blank;
      cur.error = rpt.out_error;
      if (!reset) begin
         if (prev_hold) begin
            check_eq("hold_valid", {31'b0, rpt.out_valid}, 32'd1);
            check_eq("hold_payload", 32'(cur), 32'(prev_pay));
         end
         if (rpt.out_valid && rpt.out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_report", 32'(exp_q.size()), 32'd1);
            end else begin
               exp = exp_q.pop_front();
               check_eq("rpt_value", {8'b0, cur.value}, {8'b0, exp.value});
               check_eq("rpt_blank", {26'b0, cur.blank}, {26'b0, exp.blank});
               check_eq("rpt_error", {26'b0, cur.error}, {26'b0, exp.error});
            end
         end
      end
      prev_hold = !reset && rpt.out_valid && !rpt.out_ready;
      prev_pay  = cur;
   end

   initial begin
      int n;
      reset = 1'b1;
      rpt.out_ready = 1'b1;
      set_digits(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
      step(3);

      // Reset state
      check_eq("rst_valid", {31'b0, rpt.out_valid}, 32'd0);
      check_eq("rst_value", {8'b0, rpt.out_value}, 32'd0);
      check_eq("rst_blank", {26'b0, rpt.out_blank}, 32'd0);
      check_eq("rst_error", {26'b0, rpt.out_error}, 32'd0);
      check_eq("rst_count", 32'(report_count), 32'd0);

      // First stable value after reset, with latency from the capture edge
      push(24'h000000, 6'b0, 6'b0);
      reset = 1'b0;
      wait_valid(12, n);
      check_eq("first_latency", 32'(n), Stable + 1);
      step(10);
      check_eq("count_first", 32'(report_count), cnt_mod(exp_count));

      // Short glitch produces nothing
      set_digits(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h06);
      step(2);
      set_digits(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
      step(10);
      check_eq("count_glitch", 32'(report_count), cnt_mod(exp_count));

      // Back-pressure, then newest value reported after acceptance
      rpt.out_ready = 1'b0;
      set_digits(7'h71, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F);
      push(24'hFDCBA9, 6'b0, 6'b0);
      step(20);
      check_eq("bp_valid", {31'b0, rpt.out_valid}, 32'd1);
      check_eq("bp_value", {8'b0, rpt.out_value}, 32'h00FDCBA9);
      rpt.out_ready = 1'b1;
      set_digits(7'h71, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h7F);
      push(24'hFDCBA8, 6'b0, 6'b0);
      step(12);
      check_eq("count_bp", 32'(report_count), cnt_mod(exp_count));

      // Blank and undecodable digits
      set_digits(7'h3F, 7'h3F, 7'h00, 7'h12, 7'h3F, 7'h3F);
      push(24'h000000, 6'b001000, 6'b000100);
      step(10);
      check_eq("count_blank_err", 32'(report_count), cnt_mod(exp_count));

      // Reset while a report is pending discards it
      rpt.out_ready = 1'b0;
      set_digits(7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06);
      push(24'h111111, 6'b0, 6'b0);
      wait_valid(12, n);
      reset = 1'b1;
      step(1);
      check_eq("midrst_valid", {31'b0, rpt.out_valid}, 32'd0);
      check_eq("midrst_count", 32'(report_count), 32'd0);
      check_eq("midrst_pending", 32'(exp_q.size()), 32'd1);
      exp_q.delete();
      exp_count = 0;
      push(24'h111111, 6'b0, 6'b0);
      reset = 1'b0;
      rpt.out_ready = 1'b1;
      wait_valid(12, n);
      check_eq("midrst_latency", 32'(n), Stable + 1);
      step(3);
      check_eq("midrst_recount", 32'(report_count), cnt_mod(exp_count));

      // Enough reports to wrap the counter
      for (int i = 0; i < 18; i++) begin
         int idx;
         idx = (i + 2) % 16;
         set_digits(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, seg_of(idx));
         push({20'h00000, 4'(idx)}, 6'b0, 6'b0);
         wait_valid(12, n);
         step(2);
         check_eq("count_wrap", 32'(report_count), cnt_mod(exp_count));
      end

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
